sat_accumulator: RTL and testbench



---
 rtl/sat_accumulator.sv | 123 ++++++++++++
 tb/tb_sat_accumulator.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_accumulator.sv
// Signed 16-bit saturating burst accumulator with sticky overflow, zero and negative flags.
// Optional feature macro: SAT_ACC_ABORT_EN adds an `abort` input that discards the current burst.
module sat_accumulator (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  len,
    output logic        busy,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_ovf,
    output logic        out_zero,
    output logic        out_neg,
    output logic        out_valid,
`ifdef SAT_ACC_ABORT_EN
    input  logic        abort,
`endif
    input  logic        out_ready
);

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic signed [DATA_W-1:0]   acc;
    logic [4:0]                 cnt;
    logic                       sov;
    logic                       abort_hit;
    logic                       accept;
    logic [DATA_W:0]            add_res;

    // Returns {ovf, saturated sum}; ovf is carry-in XOR carry-out of the sign bit.
    function automatic logic [DATA_W:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
        logic [DATA_W-1:0] raw;
        logic              c_out;
        logic              c_in;
        logic [DATA_W-1:0] res;
        {c_out, raw} = {1'b0, a} + {1'b0, b};
        c_in = raw[DATA_W-1] ^ a[DATA_W-1] ^ b[DATA_W-1];
        if (!a[DATA_W-1] && !b[DATA_W-1] && raw[DATA_W-1])
            res = 16'h7FFF;
        else if (a[DATA_W-1] && b[DATA_W-1] && !raw[DATA_W-1])
            res = 16'h8000;
        else
            res = raw;
        return {c_in ^ c_out, res};
    endfunction

    function automatic logic [4:0] clamp_len(input logic [4:0] l);
        return (l > 5'd16) ? 5'd16 : l;
    endfunction

`ifdef SAT_ACC_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign accept  = (state == ACC) && in_valid;
    assign add_res = sat_add(acc, in_data);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (len == 5'd0) ? DONE : ACC;
            ACC:  if (accept && cnt == 5'd1) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_hit)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || abort_hit) begin
            acc <= '0;
            cnt <= '0;
            sov <= 1'b0;
        end else if (state == IDLE && start) begin
            acc <= '0;
            cnt <= clamp_len(len);
            sov <= 1'b0;
        end else if (accept) begin
            acc <= add_res[DATA_W-1:0];
            cnt <= cnt - 5'd1;
            sov <= sov | add_res[DATA_W];
        end
    end

    // Result outputs are forced to zero outside DONE so downstream never sees a partial sum.
    always_comb begin
        busy      = (state != IDLE);
        in_ready  = (state == ACC);
        out_valid = (state == DONE);
        out_data  = '0;
        out_ovf   = 1'b0;
        out_zero  = 1'b0;
        out_neg   = 1'b0;
        if (state == DONE) begin
            out_data = acc;
            out_ovf  = sov;
            out_zero = (acc == '0);
            out_neg  = acc[DATA_W-1];
        end
    end

endmodule

// File: tb/tb_sat_accumulator.sv
// Directed bench for sat_accumulator: burst sums, saturation, len edge cases, back-pressure, reset.
module tb_sat_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  len;
    logic        busy;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_zero;
    logic        out_neg;
    logic        out_valid;
    logic        out_ready;
`ifdef SAT_ACC_ABORT_EN
    logic        abort = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sat_accumulator dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .busy(busy),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_ovf(out_ovf),
        .out_zero(out_zero),
        .out_neg(out_neg),
        .out_valid(out_valid),
`ifdef SAT_ACC_ABORT_EN
        .abort(abort),
`endif
        .out_ready(out_ready)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [4:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 5'd0;
    endtask

    task automatic feed(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 16'h0;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({busy, in_ready, out_valid, out_data, out_ovf, out_zero, out_neg} !== 22'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, in_ready, out_valid, out_data, out_ovf, out_zero, out_neg});
        end
    endtask

    task automatic test_basic_sum();
        start_burst(5'd3);
        total++;
        if ({busy, in_ready, out_valid} !== 3'b110) begin
            bad++;
            $display("FAIL basic_enter_acc: got %b want 110", {busy, in_ready, out_valid});
        end
        feed(16'h0001);
        feed(16'h0002);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_valid: got %b want 0", out_valid);
        end
        feed(16'h0003);
        total++;
        if ({out_valid, out_data, out_ovf, out_zero, out_neg} !== {1'b1, 16'h0006, 3'b000}) begin
            bad++;
            $display("FAIL basic_result: got v=%b d=%h o=%b z=%b n=%b want v=1 d=0006 o=0 z=0 n=0",
                     out_valid, out_data, out_ovf, out_zero, out_neg);
        end
        ack();
        total++;
        if ({busy, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL basic_to_idle: got %b want 00", {busy, out_valid});
        end
    endtask

    task automatic test_sat_pos();
        start_burst(5'd2);
        feed(16'h7000);
        feed(16'h2000);
        total++;
        if ({out_valid, out_data, out_ovf, out_zero, out_neg} !== {1'b1, 16'h7FFF, 3'b100}) begin
            bad++;
            $display("FAIL sat_pos: got v=%b d=%h o=%b z=%b n=%b want v=1 d=7fff o=1 z=0 n=0",
                     out_valid, out_data, out_ovf, out_zero, out_neg);
        end
        ack();
    endtask

    task automatic test_sat_neg();
        start_burst(5'd3);
        feed(16'h8000);
        feed(16'hFFFF);
        feed(16'h0005);
        total++;
        if ({out_valid, out_data, out_ovf, out_zero, out_neg} !== {1'b1, 16'h8005, 3'b101}) begin
            bad++;
            $display("FAIL sat_neg: got v=%b d=%h o=%b z=%b n=%b want v=1 d=8005 o=1 z=0 n=1",
                     out_valid, out_data, out_ovf, out_zero, out_neg);
        end
        ack();
    endtask

    task automatic test_len_zero();
        start_burst(5'd0);
        total++;
        if ({out_valid, in_ready, out_data, out_ovf, out_zero, out_neg} !== {2'b10, 16'h0000, 3'b010}) begin
            bad++;
            $display("FAIL len_zero: got v=%b r=%b d=%h o=%b z=%b n=%b want v=1 r=0 d=0000 o=0 z=1 n=0",
                     out_valid, in_ready, out_data, out_ovf, out_zero, out_neg);
        end
        ack();
        total++;
        if ({busy, in_ready, out_valid} !== 3'b000) begin
            bad++;
            $display("FAIL len_zero_idle: got %b want 000", {busy, in_ready, out_valid});
        end
    endtask

    task automatic test_len_clamp();
        start_burst(5'd20);
        for (int i = 0; i < 15; i++) feed(16'h0001);
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL clamp_after15: got %b want 10", {in_ready, out_valid});
        end
        feed(16'h0001);
        total++;
        if ({out_valid, out_data, out_ovf} !== {1'b1, 16'h0010, 1'b0}) begin
            bad++;
            $display("FAIL clamp_result: got v=%b d=%h o=%b want v=1 d=0010 o=0",
                     out_valid, out_data, out_ovf);
        end
        ack();
    endtask

    task automatic test_gap_and_wrap();
        start_burst(5'd2);
        feed(16'h0005);
        tick();
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL gap_hold: got %b want 10", {in_ready, out_valid});
        end
        feed(16'hFFF0);
        total++;
        if ({out_valid, out_data, out_ovf, out_zero, out_neg} !== {1'b1, 16'hFFF5, 3'b001}) begin
            bad++;
            $display("FAIL gap_result: got v=%b d=%h o=%b z=%b n=%b want v=1 d=fff5 o=0 z=0 n=1",
                     out_valid, out_data, out_ovf, out_zero, out_neg);
        end
        ack();
    endtask

    task automatic test_backpressure();
        start_burst(5'd1);
        feed(16'h1234);
        for (int i = 0; i < 5; i++) begin
            start    = i[0];
            len      = 5'd2;
            in_valid = 1'b1;
            in_data  = 16'h0100;
            tick();
            total++;
            if ({out_valid, in_ready, busy, out_data, out_ovf, out_zero, out_neg} !== {3'b101, 16'h1234, 3'b000}) begin
                bad++;
                $display("FAIL backpressure_hold%0d: got v=%b r=%b b=%b d=%h o=%b z=%b n=%b want v=1 r=0 b=1 d=1234 flags=000",
                         i, out_valid, in_ready, busy, out_data, out_ovf, out_zero, out_neg);
            end
        end
        start    = 1'b0;
        len      = 5'd0;
        in_valid = 1'b0;
        ack();
        total++;
        if ({busy, out_valid, in_ready} !== 3'b000) begin
            bad++;
            $display("FAIL backpressure_release: got %b want 000", {busy, out_valid, in_ready});
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_no_queue: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        start_burst(5'd4);
        feed(16'h0100);
        feed(16'h0200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, in_ready, out_valid, out_data, out_ovf, out_zero, out_neg} !== 22'h0) begin
            bad++;
            $display("FAIL mid_reset: got %h want 0",
                     {busy, in_ready, out_valid, out_data, out_ovf, out_zero, out_neg});
        end
        start_burst(5'd1);
        feed(16'h0010);
        total++;
        if ({out_valid, out_data, out_ovf} !== {1'b1, 16'h0010, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_burst: got v=%b d=%h o=%b want v=1 d=0010 o=0",
                     out_valid, out_data, out_ovf);
        end
        ack();
    endtask

`ifdef SAT_ACC_ABORT_EN
    task automatic test_abort();
        start_burst(5'd3);
        feed(16'h0007);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0001;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({busy, in_ready, out_valid, out_data} !== 19'h0) begin
            bad++;
            $display("FAIL abort_acc: got %h want 0", {busy, in_ready, out_valid, out_data});
        end
        start_burst(5'd1);
        feed(16'h0003);
        total++;
        if ({out_valid, out_data} !== {1'b1, 16'h0003}) begin
            bad++;
            $display("FAIL abort_clears_acc: got v=%b d=%h want v=1 d=0003", out_valid, out_data);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({busy, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL abort_done: got %b want 00", {busy, out_valid});
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 5'd0;
        in_data   = 16'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic_sum();
        test_sat_pos();
        test_sat_neg();
        test_len_zero();
        test_len_clamp();
        test_gap_and_wrap();
        test_backpressure();
        test_mid_reset();
`ifdef SAT_ACC_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
